// File: rtl/pulpemu_ctrl_if.sv
// Control/status bundle between the PS-side control words and the core sequencer.
// The master side (PS or bench) drives control and core status; the slave side
// (pulpemu_ctrl) drives core reset, fetch enables and the packed status words.
interface pulpemu_ctrl_if #(
  parameter int unsigned NUM_CORES = 1,
  parameter int unsigned RET_W     = 2
);
  logic [31:0]                ctrl_i;
  logic [NUM_CORES-1:0]       eoc_i;
  logic [NUM_CORES*RET_W-1:0] return_i;
  logic                       core_rst_n_o;
  logic [NUM_CORES-1:0]       fetch_en_o;
  logic [31:0]                status_o;
  logic [31:0]                run_cycles_o;

  modport master (
    output ctrl_i,
    output eoc_i,
    output return_i,
    input  core_rst_n_o,
    input  fetch_en_o,
    input  status_o,
    input  run_cycles_o
  );

  modport slave (
    input  ctrl_i,
    input  eoc_i,
    input  return_i,
    output core_rst_n_o,
    output fetch_en_o,
    output status_o,
    output run_cycles_o
  );
endinterface

// File: rtl/pulpemu_ctrl.sv
// Core control/status sequencer: sequenced core reset, debounced per-core fetch enables,
// sticky end-of-computation/return-code capture and a saturating run-time counter.
module pulpemu_ctrl #(
  parameter int unsigned NUM_CORES   = 1,
  parameter int unsigned RET_W       = 2,
  parameter int unsigned DEB_CYCLES  = 32,
  parameter int unsigned RST_MIN     = 16,
  parameter int unsigned WAKE_CYCLES = 8
) (
  input  logic          clk,
  input  logic          rst,
  pulpemu_ctrl_if.slave bus
);

  localparam int unsigned HoldW = $clog2(RST_MIN + 1);
  localparam int unsigned WakeW = $clog2(WAKE_CYCLES + 1);
  localparam int unsigned DebW  = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    StReset = 2'd0,
    StWake  = 2'd1,
    StRun   = 2'd2
  } state_e;

  state_e                     r_state;
  logic [HoldW-1:0]           r_hold_cnt;
  logic [WakeW-1:0]           r_wake_cnt;
  logic                       r_core_rst_n;
  logic [NUM_CORES-1:0]       r_fetch_en;
  logic [NUM_CORES-1:0]       r_eoc_q;
  logic [NUM_CORES-1:0]       r_sticky;
  logic [NUM_CORES*RET_W-1:0] r_ret;
  logic [31:0]                r_run_cycles;
  logic [31:0]                r_status;
  logic [NUM_CORES-1:0]       r_deb;
  logic [DebW-1:0]            r_deb_cnt [NUM_CORES];

  logic [NUM_CORES-1:0]       w_deb_d;
  logic [DebW-1:0]            w_deb_cnt_d [NUM_CORES];
  logic [NUM_CORES-1:0]       w_rise;
  logic                       w_all_done;
  logic [31:0]                w_status;
  logic                       w_unused_ctrl;

  // Bits between the fetch-enable requests and the run bit carry no meaning.
  assign w_unused_ctrl = ^bus.ctrl_i[30:NUM_CORES];

  // Debounce next state: flip only after DEB_CYCLES consecutive mismatching samples.
  always_comb begin
    w_deb_d = r_deb;
    for (int c = 0; c < int'(NUM_CORES); c++) begin
      w_deb_cnt_d[c] = '0;
      if (bus.ctrl_i[c] != r_deb[c]) begin
        if (r_deb_cnt[c] == DebW'(DEB_CYCLES - 1)) begin
          w_deb_d[c] = ~r_deb[c];
        end else begin
          w_deb_cnt_d[c] = r_deb_cnt[c] + DebW'(1);
        end
      end
    end
  end

  // Debouncer state; survives the FSM reset, only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb <= '0;
      for (int c = 0; c < int'(NUM_CORES); c++) r_deb_cnt[c] <= '0;
    end else begin
      r_deb <= w_deb_d;
      for (int c = 0; c < int'(NUM_CORES); c++) r_deb_cnt[c] <= w_deb_cnt_d[c];
    end
  end

  // First EOC edge per core while RUN and not yet captured; completion of all enabled cores.
  always_comb begin
    w_rise     = bus.eoc_i & ~r_eoc_q & ~r_sticky;
    w_all_done = (r_state == StRun) && (r_deb != '0) && ((r_sticky & r_deb) == r_deb);
  end

  // Sequencer FSM with registered core reset, fetch enables, capture and run counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StReset;
      r_hold_cnt   <= HoldW'(RST_MIN - 1);
      r_wake_cnt   <= '0;
      r_core_rst_n <= 1'b0;
      r_fetch_en   <= '0;
      r_eoc_q      <= '0;
      r_sticky     <= '0;
      r_ret        <= '0;
      r_run_cycles <= '0;
    end else begin
      unique case (r_state)
        StReset: begin
          r_core_rst_n <= 1'b0;
          r_fetch_en   <= '0;
          r_eoc_q      <= '0;
          r_sticky     <= '0;
          r_ret        <= '0;
          r_run_cycles <= '0;
          r_wake_cnt   <= '0;
          if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - HoldW'(1);
          end else if (bus.ctrl_i[31]) begin
            r_state      <= StWake;
            r_core_rst_n <= 1'b1;
          end
        end
        StWake: begin
          r_eoc_q <= '0;
          if (!bus.ctrl_i[31]) begin
            r_state      <= StReset;
            r_hold_cnt   <= HoldW'(RST_MIN - 1);
            r_core_rst_n <= 1'b0;
            r_fetch_en   <= '0;
          end else if (r_wake_cnt == WakeW'(WAKE_CYCLES - 1)) begin
            r_state    <= StRun;
            r_fetch_en <= w_deb_d;
          end else begin
            r_wake_cnt <= r_wake_cnt + WakeW'(1);
            r_fetch_en <= '0;
          end
        end
        StRun: begin
          r_eoc_q  <= bus.eoc_i;
          r_sticky <= r_sticky | w_rise;
          for (int c = 0; c < int'(NUM_CORES); c++) begin
            if (w_rise[c]) r_ret[c*RET_W +: RET_W] <= bus.return_i[c*RET_W +: RET_W];
          end
          if (!w_all_done && (r_run_cycles != '1)) begin
            r_run_cycles <= r_run_cycles + 32'd1;
          end
          if (!bus.ctrl_i[31]) begin
            r_state      <= StReset;
            r_hold_cnt   <= HoldW'(RST_MIN - 1);
            r_core_rst_n <= 1'b0;
            r_fetch_en   <= '0;
          end else begin
            r_fetch_en <= w_deb_d;
          end
        end
        default: begin
          r_state      <= StReset;
          r_hold_cnt   <= HoldW'(RST_MIN - 1);
          r_core_rst_n <= 1'b0;
          r_fetch_en   <= '0;
        end
      endcase
    end
  end

  // Packed status view of the current internal state.
  always_comb begin
    w_status                  = '0;
    w_status[NUM_CORES-1:0]   = r_sticky;
    for (int c = 0; c < int'(NUM_CORES); c++) begin
      w_status[8+c*2 +: RET_W] = r_ret[c*RET_W +: RET_W];
    end
    w_status[29:28]           = r_state;
    w_status[30]              = w_all_done;
    w_status[31]              = r_core_rst_n;
  end

  // Status word register, one cycle behind the internal state.
  always_ff @(posedge clk) begin
    if (rst) r_status <= '0;
    else     r_status <= w_status;
  end

  assign bus.core_rst_n_o = r_core_rst_n;
  assign bus.fetch_en_o   = r_fetch_en;
  assign bus.status_o     = r_status;
  assign bus.run_cycles_o = r_run_cycles;

endmodule

// File: tb/tb_pulpemu_ctrl.sv
// Directed bench for pulpemu_ctrl: a table of {inputs, hold cycles, expected outputs}
// steps walked from reset, plus a hand-written run-counter saturation sequence.
module tb_pulpemu_ctrl;

  localparam int unsigned NC = 2;
  localparam int unsigned RW = 2;

  logic clk = 1'b0;
  logic rst;

  pulpemu_ctrl_if #(.NUM_CORES(NC), .RET_W(RW)) bus ();

  pulpemu_ctrl #(
    .NUM_CORES  (NC),
    .RET_W      (RW),
    .DEB_CYCLES (32),
    .RST_MIN    (16),
    .WAKE_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned cycles;
    logic [31:0] ctrl;
    logic [1:0]  eoc;
    logic [3:0]  ret;
    logic        exp_rst_n;
    logic [1:0]  exp_fetch;
    logic [31:0] exp_status;
    logic [31:0] exp_run;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void add(string name, int unsigned cycles, logic [31:0] ctrl,
                              logic [1:0] eoc, logic [3:0] ret, logic rst_n,
                              logic [1:0] fetch, logic [31:0] status, logic [31:0] run);
    vec_t v;
    v.name = name; v.cycles = cycles; v.ctrl = ctrl; v.eoc = eoc; v.ret = ret;
    v.exp_rst_n = rst_n; v.exp_fetch = fetch; v.exp_status = status; v.exp_run = run;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check_outputs(string name, logic rst_n, logic [1:0] fetch,
                               logic [31:0] status, logic [31:0] run);
    check({name, ".core_rst_n"}, {31'd0, bus.core_rst_n_o}, {31'd0, rst_n});
    check({name, ".fetch_en"},   {30'd0, bus.fetch_en_o},   {30'd0, fetch});
    check({name, ".status"},     bus.status_o,              status);
    check({name, ".run_cycles"}, bus.run_cycles_o,          run);
  endtask

  initial begin
    // Timeline in edges after rst drops: WAKE at 16, RUN at 24, deb[0] flips at 32.
    add("hold_end",     15, 32'h8000_0001, 2'b00, 4'b0000, 1'b0, 2'b00, 32'h0000_0000, 0);
    add("rst_release",   1, 32'h8000_0001, 2'b00, 4'b0000, 1'b1, 2'b00, 32'h0000_0000, 0);
    add("wake_status",   1, 32'h8000_0001, 2'b00, 4'b0000, 1'b1, 2'b00, 32'h9000_0000, 0);
    add("wake_last",     7, 32'h8000_0001, 2'b00, 4'b0000, 1'b1, 2'b00, 32'h9000_0000, 0);
    add("run_entry",     1, 32'h8000_0001, 2'b00, 4'b0000, 1'b1, 2'b00, 32'hA000_0000, 1);
    add("deb_pending",   6, 32'h8000_0001, 2'b00, 4'b0000, 1'b1, 2'b00, 32'hA000_0000, 7);
    add("deb_rise",      1, 32'h8000_0001, 2'b00, 4'b0000, 1'b1, 2'b01, 32'hA000_0000, 8);
    add("run_nodone",    1, 32'h8000_0001, 2'b00, 4'b0000, 1'b1, 2'b01, 32'hA000_0000, 9);
    // Core1 request glitch of DEB_CYCLES-1, then a full DEB_CYCLES hold.
    add("glitch_hi",    31, 32'h8000_0003, 2'b00, 4'b0000, 1'b1, 2'b01, 32'hA000_0000, 40);
    add("glitch_lo",     1, 32'h8000_0001, 2'b00, 4'b0000, 1'b1, 2'b01, 32'hA000_0000, 41);
    add("hold_31",      31, 32'h8000_0003, 2'b00, 4'b0000, 1'b1, 2'b01, 32'hA000_0000, 72);
    add("hold_32",       1, 32'h8000_0003, 2'b00, 4'b0000, 1'b1, 2'b11, 32'hA000_0000, 73);
    // Core0 EOC with code 01, second pulse with code 11 ignored, core1 EOC with code 10.
    add("eoc0_edge",     1, 32'h8000_0003, 2'b01, 4'b0001, 1'b1, 2'b11, 32'hA000_0000, 74);
    add("eoc0_status",   1, 32'h8000_0003, 2'b00, 4'b0010, 1'b1, 2'b11, 32'hA000_0101, 75);
    add("eoc0_repulse",  1, 32'h8000_0003, 2'b01, 4'b0011, 1'b1, 2'b11, 32'hA000_0101, 76);
    add("eoc0_kept",    97, 32'h8000_0003, 2'b00, 4'b0000, 1'b1, 2'b11, 32'hA000_0101, 173);
    add("eoc1_edge",     1, 32'h8000_0003, 2'b10, 4'b1000, 1'b1, 2'b11, 32'hA000_0101, 174);
    add("all_done",      1, 32'h8000_0003, 2'b10, 4'b1000, 1'b1, 2'b11, 32'hE000_0903, 174);
    add("frozen",        5, 32'h8000_0003, 2'b10, 4'b1000, 1'b1, 2'b11, 32'hE000_0903, 174);
    // One-cycle run drop; core1 EOC stays high through RESET/WAKE into the next RUN.
    add("drop_run",      1, 32'h0000_0003, 2'b10, 4'b1000, 1'b0, 2'b00, 32'hE000_0903, 174);
    add("reset_clear",   1, 32'h8000_0003, 2'b10, 4'b1000, 1'b0, 2'b00, 32'h0000_0903, 0);
    add("reset_status",  1, 32'h8000_0003, 2'b10, 4'b1000, 1'b0, 2'b00, 32'h0000_0000, 0);
    add("hold_again",   13, 32'h8000_0003, 2'b10, 4'b1000, 1'b0, 2'b00, 32'h0000_0000, 0);
    add("rewake",        1, 32'h8000_0003, 2'b10, 4'b1000, 1'b1, 2'b00, 32'h0000_0000, 0);
    add("rerun",         8, 32'h8000_0003, 2'b10, 4'b1000, 1'b1, 2'b11, 32'h9000_0000, 0);
    add("rerun_status",  1, 32'h8000_0003, 2'b10, 4'b1000, 1'b1, 2'b11, 32'hA000_0000, 1);
    add("eoc_held",      1, 32'h8000_0003, 2'b10, 4'b1000, 1'b1, 2'b11, 32'hA000_0802, 2);

    rst          = 1'b1;
    bus.ctrl_i   = 32'h0;
    bus.eoc_i    = '0;
    bus.return_i = '0;
    repeat (3) @(negedge clk);
    check_outputs("reset", 1'b0, 2'b00, 32'h0, 32'h0);

    rst = 1'b0;
    foreach (vecs[i]) begin
      bus.ctrl_i   = vecs[i].ctrl;
      bus.eoc_i    = vecs[i].eoc;
      bus.return_i = vecs[i].ret;
      repeat (vecs[i].cycles) @(negedge clk);
      check_outputs(vecs[i].name, vecs[i].exp_rst_n, vecs[i].exp_fetch,
                    vecs[i].exp_status, vecs[i].exp_run);
    end

    // Run counter near its ceiling: core0 not done, so counting continues and must saturate.
    bus.eoc_i = 2'b00;
    force dut.r_run_cycles = 32'hFFFF_FFFC;
    @(negedge clk);
    release dut.r_run_cycles;
    check("sat_near", {31'd0, bus.run_cycles_o >= 32'hFFFF_FFFC}, 32'd1);
    repeat (3) @(negedge clk);
    check("sat_reach", bus.run_cycles_o, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    check("sat_hold", bus.run_cycles_o, 32'hFFFF_FFFF);
    check("sat_not_done", {31'd0, bus.status_o[30]}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
